// File: rtl/cim_pkg.sv
// Shared definitions for the CIM filter issue path: state encoding,
// index-width derivation and the default decoder timeout.
package cim_pkg;

  localparam int unsigned MAX_WAIT_DEFAULT = 100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMPUTE,
    ST_DONE
  } state_e;

  // Index width for an output-channel count; never narrower than one bit.
  function automatic int unsigned bit_out_ch(input int unsigned out_ch);
    return (out_ch > 1) ? $clog2(out_ch) : 1;
  endfunction

endpackage

// File: rtl/slot_index_gen.sv
// Packs the filter indices of one group into per-slot fields and flags
// which slots hold a real filter of the current layer.
module slot_index_gen
  import cim_pkg::*;
#(
  parameter int unsigned G          = 1,
  parameter int unsigned BIT_OUT_CH = 6,
  parameter int unsigned GRP_W      = 7
) (
  input  logic [GRP_W-1:0]        group,
  input  logic [BIT_OUT_CH:0]     num_och,
  output logic [G*BIT_OUT_CH-1:0] which_filter_c,
  output logic [G-1:0]            slot_mask_c
);

  always_comb begin
    which_filter_c = '0;
    slot_mask_c    = '0;
    for (int unsigned k = 0; k < G; k++) begin
      if ((32'(group) * G + k) < 32'(num_och)) begin
        which_filter_c[k*BIT_OUT_CH +: BIT_OUT_CH] = BIT_OUT_CH'(32'(group) * G + k);
        slot_mask_c[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/filter_issue_ctrl.sv
// Walks a layer's output-channel filters group by group: issues each group
// to the filter decoder, waits for its response, then holds a compute window.
module filter_issue_ctrl
  import cim_pkg::*;
#(
  parameter int unsigned NUM_MACRO      = 1,
  parameter int unsigned MAX_NUM_FILTER = 1,
  parameter int unsigned OUT_CH         = 64,
  parameter int unsigned MAX_WAIT       = MAX_WAIT_DEFAULT,
  localparam int unsigned BIT_OUT_CH    = bit_out_ch(OUT_CH),
  localparam int unsigned G             = NUM_MACRO * MAX_NUM_FILTER
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [BIT_OUT_CH:0]     layer_och,
  input  logic [7:0]              compute_cycles,
  input  logic                    dec_out_valid,
  output logic                    in_valid,
  output logic [G*BIT_OUT_CH-1:0] WHICH_FILTER,
  output logic [G-1:0]            slot_mask,
  output logic                    compute_en,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int unsigned OCH_W     = BIT_OUT_CH + 1;
  localparam int unsigned GRP_W     = BIT_OUT_CH + 1;
  localparam int unsigned WAIT_BITS = $clog2(MAX_WAIT + 1);
  localparam int unsigned CNT_W     = (WAIT_BITS > 8) ? WAIT_BITS : 8;

  state_e                  state_q, state_d;
  logic [GRP_W-1:0]        group_q, group_d;
  logic [OCH_W-1:0]        och_q, och_d;
  logic [7:0]              cc_q, cc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    err_q, err_d;

  logic                    in_valid_q, in_valid_d;
  logic [G*BIT_OUT_CH-1:0] which_filter_q, which_filter_d;
  logic [G-1:0]            slot_mask_q, slot_mask_d;
  logic                    compute_en_q, compute_en_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    last_grp_c;
  logic [OCH_W-1:0]        och_clamped_c;
  logic [G*BIT_OUT_CH-1:0] wf_c;
  logic [G-1:0]            mask_c;

  assign last_grp_c = ((32'(group_q) + 32'd1) * G) >= 32'(och_q);

  // Zero channels means one; anything past the array size saturates.
  always_comb begin
    och_clamped_c = layer_och;
    if (layer_och == '0)                       och_clamped_c = OCH_W'(1);
    else if (32'(layer_och) > OUT_CH)          och_clamped_c = OCH_W'(OUT_CH);
  end

  always_comb begin : next_state
    state_d = state_q;
    group_d = group_q;
    och_d   = och_q;
    cc_d    = cc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          group_d = '0;
          och_d   = och_clamped_c;
          cc_d    = (compute_cycles == 8'd0) ? 8'd1 : compute_cycles;
          err_d   = 1'b0;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
        cnt_d   = '0;
      end
      ST_WAIT: begin
        if (dec_out_valid) begin
          state_d = ST_COMPUTE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_COMPUTE: begin
        if (cnt_q == CNT_W'(cc_q - 8'd1)) begin
          if (last_grp_c) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            group_d = group_q + GRP_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  slot_index_gen #(
    .G          (G),
    .BIT_OUT_CH (BIT_OUT_CH),
    .GRP_W      (GRP_W)
  ) u_slot_index_gen (
    .group          (group_d),
    .num_och        (och_d),
    .which_filter_c (wf_c),
    .slot_mask_c    (mask_c)
  );

  // Outputs are decoded from the next state so they line up with it once registered.
  always_comb begin : output_decode
    in_valid_d     = (state_d == ST_ISSUE);
    compute_en_d   = (state_d == ST_COMPUTE);
    busy_d         = (state_d != ST_IDLE);
    done_d         = (state_d == ST_DONE);
    which_filter_d = (state_d == ST_ISSUE) ? wf_c : '0;
    slot_mask_d    = '0;
    if (state_d == ST_ISSUE || state_d == ST_WAIT || state_d == ST_COMPUTE) begin
      slot_mask_d = mask_c;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      group_q        <= '0;
      och_q          <= '0;
      cc_q           <= '0;
      cnt_q          <= '0;
      err_q          <= 1'b0;
      in_valid_q     <= 1'b0;
      which_filter_q <= '0;
      slot_mask_q    <= '0;
      compute_en_q   <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      group_q        <= group_d;
      och_q          <= och_d;
      cc_q           <= cc_d;
      cnt_q          <= cnt_d;
      err_q          <= err_d;
      in_valid_q     <= in_valid_d;
      which_filter_q <= which_filter_d;
      slot_mask_q    <= slot_mask_d;
      compute_en_q   <= compute_en_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign in_valid     = in_valid_q;
  assign WHICH_FILTER = which_filter_q;
  assign slot_mask    = slot_mask_q;
  assign compute_en   = compute_en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_filter_issue_ctrl.sv
// Bench for filter_issue_ctrl: two configurations (1x1 and 2x2 slots) driven
// by directed layers, checked every cycle against an expected timeline.
module tb_filter_issue_ctrl;

  localparam int MAXC = 256;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] layer_och;
  logic [7:0] cmp_cyc;
  logic       start_a, start_b, dov_a, dov_b;

  logic        iv_a, ce_a, busy_a, done_a, err_a;
  logic [5:0]  wf_a;
  logic [0:0]  mask_a;
  logic        iv_b, ce_b, busy_b, done_b, err_b;
  logic [23:0] wf_b;
  logic [3:0]  mask_b;

  filter_issue_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .layer_och(layer_och),
    .compute_cycles(cmp_cyc), .dec_out_valid(dov_a), .in_valid(iv_a),
    .WHICH_FILTER(wf_a), .slot_mask(mask_a), .compute_en(ce_a),
    .busy(busy_a), .done(done_a), .err(err_a)
  );

  filter_issue_ctrl #(.NUM_MACRO(2), .MAX_NUM_FILTER(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .layer_och(layer_och),
    .compute_cycles(cmp_cyc), .dec_out_valid(dov_b), .in_valid(iv_b),
    .WHICH_FILTER(wf_b), .slot_mask(mask_b), .compute_en(ce_b),
    .busy(busy_b), .done(done_b), .err(err_b)
  );

  always #5 clk = ~clk;

  // Expected timeline per DUT (index 0 = 1x1, 1 = 2x2), and its stimulus.
  logic        e_iv[2][MAXC], e_ce[2][MAXC], e_busy[2][MAXC], e_done[2][MAXC], e_err[2][MAXC];
  logic [23:0] e_wf[2][MAXC];
  logic [3:0]  e_mask[2][MAXC];
  logic        s_start[2][MAXC], s_dov[2][MAXC];
  logic        s_rstn[MAXC];

  int  total = 0;
  int  bad   = 0;
  int  cur   = 0;
  int  scn   = 0;
  bit  checking = 1'b0;
  logic errst[2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input int c, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s scn=%0d cyc=%0d got=%h want=%h", nm, scn, c, act, exp);
    end
  endtask

  // Group contents from first principles: slot k of group g is filter g*G+k if it exists.
  function automatic logic [27:0] pack(input int grp, input int g, input int och_e);
    logic [23:0] wf;
    logic [3:0]  m;
    wf = '0;
    m  = '0;
    for (int k = 0; k < grp; k++) begin
      int idx;
      idx = g * grp + k;
      if (idx < och_e) begin
        wf[k*6 +: 6] = 6'(idx);
        m[k]         = 1'b1;
      end
    end
    return {m, wf};
  endfunction

  task automatic build(input int d, input int grp, input int och, input int cc, input int lat,
                       input int rst_at, input bit noise, output int len);
    int och_e, cc_e, n, p, b, fin;
    logic [27:0] pk;
    och_e = (och == 0) ? 1 : ((och > 64) ? 64 : och);
    cc_e  = (cc == 0) ? 1 : cc;
    n     = (och_e + grp - 1) / grp;
    for (int c = 0; c < MAXC; c++) begin
      e_iv[d][c] = 0; e_ce[d][c] = 0; e_busy[d][c] = 0; e_done[d][c] = 0; e_err[d][c] = 0;
      e_wf[d][c] = '0; e_mask[d][c] = '0;
      s_start[d][c] = 0; s_dov[d][c] = 0; s_rstn[c] = 1;
    end
    e_err[d][0]   = errst[d];
    s_start[d][0] = 1;
    if (lat == 0) begin
      pk = pack(grp, 0, och_e);
      e_iv[d][1] = 1;
      e_wf[d][1] = pk[23:0];
      for (int c = 1; c <= 101; c++) begin
        e_mask[d][c] = pk[27:24];
        e_busy[d][c] = 1;
      end
      for (int c = 102; c < MAXC; c++) e_err[d][c] = 1;
      len = 104;
    end else begin
      p = 1 + lat + cc_e;
      for (int g = 0; g < n; g++) begin
        b  = 1 + g * p;
        pk = pack(grp, g, och_e);
        e_iv[d][b] = 1;
        e_wf[d][b] = pk[23:0];
        for (int c = b; c <= b + lat + cc_e; c++) e_mask[d][c] = pk[27:24];
        for (int c = b + lat + 1; c <= b + lat + cc_e; c++) e_ce[d][c] = 1;
        s_dov[d][b + lat] = 1;
      end
      fin = 1 + n * p;
      for (int c = 1; c <= fin; c++) e_busy[d][c] = 1;
      e_done[d][fin] = 1;
      len = fin + 2;
      if (noise) begin
        s_start[d][2] = 1;
        s_start[d][fin - 1] = 1;
        s_start[d][fin] = 1;
        s_dov[d][1] = 1;
        s_dov[d][lat + 2] = 1;
      end
    end
    if (rst_at >= 0) begin
      s_rstn[rst_at] = 0;
      for (int c = rst_at + 1; c < MAXC; c++) begin
        e_iv[d][c] = 0; e_ce[d][c] = 0; e_busy[d][c] = 0; e_done[d][c] = 0; e_err[d][c] = 0;
        e_wf[d][c] = '0; e_mask[d][c] = '0; s_start[d][c] = 0; s_dov[d][c] = 0;
      end
      len = rst_at + 3;
    end
  endtask

  task automatic run(input int len, input bit noise);
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      cur      = c;
      checking = 1'b1;
      start_a  = s_start[0][c];
      start_b  = s_start[1][c];
      dov_a    = s_dov[0][c];
      dov_b    = s_dov[1][c];
      rst_n    = s_rstn[c];
      if (noise && c > 0) begin
        layer_och = 7'd50;
        cmp_cyc   = 8'd7;
      end
    end
    @(negedge clk); #1;
    checking = 1'b0;
  endtask

  task automatic scenario(input int id, input int och, input int cc, input int lat,
                          input int rst_at, input bit noise);
    int la, lb, l;
    scn       = id;
    layer_och = 7'(och);
    cmp_cyc   = 8'(cc);
    build(0, 1, och, cc, lat, rst_at, noise, la);
    build(1, 4, och, cc, lat, rst_at, noise, lb);
    l = (la > lb) ? la : lb;
    run(l, noise);
    errst[0] = e_err[0][l - 1];
    errst[1] = e_err[1][l - 1];
  endtask

  // Per-cycle comparison against the timeline, plus hand-computed pins.
  always @(negedge clk) begin
    if (checking) begin
      chk("in_valid_a", cur, 24'(iv_a), 24'(e_iv[0][cur]));
      chk("filter_a",   cur, 24'(wf_a), e_wf[0][cur]);
      chk("mask_a",     cur, 24'(mask_a), 24'(e_mask[0][cur]));
      chk("compute_a",  cur, 24'(ce_a), 24'(e_ce[0][cur]));
      chk("busy_a",     cur, 24'(busy_a), 24'(e_busy[0][cur]));
      chk("done_a",     cur, 24'(done_a), 24'(e_done[0][cur]));
      chk("err_a",      cur, 24'(err_a), 24'(e_err[0][cur]));
      chk("in_valid_b", cur, 24'(iv_b), 24'(e_iv[1][cur]));
      chk("filter_b",   cur, wf_b, e_wf[1][cur]);
      chk("mask_b",     cur, 24'(mask_b), 24'(e_mask[1][cur]));
      chk("compute_b",  cur, 24'(ce_b), 24'(e_ce[1][cur]));
      chk("busy_b",     cur, 24'(busy_b), 24'(e_busy[1][cur]));
      chk("done_b",     cur, 24'(done_b), 24'(e_done[1][cur]));
      chk("err_b",      cur, 24'(err_b), 24'(e_err[1][cur]));
      case (scn)
        1: begin
          if (cur == 1)  chk("pin_iv1",  cur, {iv_a, 17'd0, wf_a}, 24'h800000);
          if (cur == 5)  chk("pin_iv5",  cur, {iv_a, 17'd0, wf_a}, 24'h800001);
          if (cur == 9)  chk("pin_iv9",  cur, {iv_a, 17'd0, wf_a}, 24'h800002);
          if (cur == 3 || cur == 4) chk("pin_ce", cur, 24'(ce_a), 24'd1);
          if (cur == 12) chk("pin_done12", cur, 24'(done_a), 24'd0);
          if (cur == 13) chk("pin_done13", cur, 24'(done_a), 24'd1);
        end
        2: begin
          if (cur == 1) chk("pin_g0_wf",   cur, wf_b, 24'h0C2040);
          if (cur == 1) chk("pin_g0_mask", cur, 24'(mask_b), 24'h00000F);
          if (cur == 4) chk("pin_g1_wf",   cur, wf_b, 24'h000004);
          if (cur == 5) chk("pin_g1_mask", cur, 24'(mask_b), 24'h000001);
        end
        4: begin
          if (cur == 101) chk("pin_to_busy", cur, {22'd0, busy_a, err_a}, 24'd2);
          if (cur == 102) chk("pin_to_err",  cur, {22'd0, busy_a, err_a}, 24'd1);
        end
        5: begin
          if (cur == 0) chk("pin_err_held",  cur, 24'(err_a), 24'd1);
          if (cur == 1) chk("pin_err_clear", cur, 24'(err_a), 24'd0);
        end
        6: if (cur == 10) chk("pin_rst_idle", cur, {20'd0, busy_a, ce_a, mask_a, iv_a}, 24'd0);
        7: if (cur == 1)  chk("pin_restart",  cur, {iv_a, 17'd0, wf_a}, 24'h800000);
        default: ;
      endcase
    end
  end

  initial begin
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; dov_a = 1'b0; dov_b = 1'b0;
    layer_och = 7'd0; cmp_cyc = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_a", 0, {17'd0, iv_a, ce_a, busy_a, done_a, err_a, mask_a, wf_a[0]}, 24'd0);
    chk("reset_wf_a", 0, 24'(wf_a), 24'd0);
    chk("reset_b", 0, {16'd0, iv_b, ce_b, busy_b, done_b, err_b, mask_b[2:0]}, 24'd0);
    chk("reset_wf_b", 0, wf_b, 24'd0);
    #1;
    scenario(1, 3, 2, 1, -1, 1'b0);
    scenario(2, 5, 1, 1, -1, 1'b0);
    scenario(3, 3, 2, 2, -1, 1'b1);
    scenario(4, 2, 2, 0, -1, 1'b0);
    scenario(5, 3, 1, 1, -1, 1'b0);
    scenario(6, 3, 3, 1, 9, 1'b0);
    scenario(7, 2, 1, 1, -1, 1'b0);
    scenario(8, 64, 0, 1, -1, 1'b0);
    scenario(9, 0, 1, 1, -1, 1'b0);
    scenario(10, 100, 0, 1, -1, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
